addsub_arbiter: RTL and testbench

//  - Shares one WIDTH-bit adder-subtractor (M=0: A+B, M=1: A-B) between two requesters.
//  - Round-robin arbitration, valid/ready request handshake, registered result with a response handshake.
//  - Sits between the two client datapaths and the arithmetic unit; serialises their operations.

---
 rtl/addsub_arbiter_if.sv | 42 ++++
 rtl/addsub_arbiter.sv | 116 +++++++++++
 tb/tb_addsub_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/addsub_arbiter_if.sv
// Request/response bus between two clients, their result consumer and the
// shared adder-subtractor arbiter.
//   master : client side; drives requests and rsp_ready, observes grants/results
//   slave  : arbiter side; drives req_ready and the rsp_* result
// Requester i uses bit i of req_valid/req_ready/req_mode and slice
// [i*WIDTH +: WIDTH] of req_a/req_b.
// OVERFLOW_FLAG_EN adds the rsp_ovf result bit.
interface addsub_arbiter_if #(
  parameter int unsigned WIDTH = 4
) ();

  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [1:0]         req_mode;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [WIDTH-1:0]   rsp_sum;
  logic               rsp_carry;
`ifdef OVERFLOW_FLAG_EN
  logic               rsp_ovf;
`endif

  modport master (
`ifdef OVERFLOW_FLAG_EN
    input  rsp_ovf,
`endif
    output req_valid, req_mode, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
  );

  modport slave (
`ifdef OVERFLOW_FLAG_EN
    output rsp_ovf,
`endif
    input  req_valid, req_mode, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
  );

endinterface

// File: rtl/addsub_arbiter.sv
// Shares one WIDTH-bit adder-subtractor (mode 0: A+B, mode 1: A-B) between
// two requesters with round-robin arbitration. One operation in flight;
// FSM IDLE -> EXEC -> RESP -> IDLE.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : addsub_arbiter_if.slave (request handshake + registered result)
//   busy   : 1 whenever the FSM is not in IDLE
// Optional feature: define OVERFLOW_FLAG_EN to add the two's-complement
// overflow result bit bus.rsp_ovf.
module addsub_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  addsub_arbiter_if.slave bus,
  output logic           busy
);

  localparam int unsigned SUM_W = WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               prio_q;
  logic               op_mode_q;
  logic               op_id_q;
  logic [WIDTH-1:0]   op_a_q;
  logic [WIDTH-1:0]   op_b_q;
  logic               grant_id_c;
  logic               accept_c;
  logic [WIDTH-1:0]   b_eff_c;
  logic [SUM_W-1:0]   sum_c;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant / request handshake; the grant is only offered in IDLE and out of reset
  always_comb begin
    grant_id_c    = 1'b0;
    accept_c      = 1'b0;
    bus.req_ready = 2'b00;
    if (bus.req_valid == 2'b11) grant_id_c = prio_q;
    else                        grant_id_c = bus.req_valid[1];
    if (rst_n && (state_q == IDLE) && (|bus.req_valid)) begin
      accept_c                  = 1'b1;
      bus.req_ready[grant_id_c] = 1'b1;
    end
  end

  // Shared adder: subtract is A + ~B + 1
  always_comb begin
    b_eff_c = op_mode_q ? ~op_b_q : op_b_q;
    sum_c   = SUM_W'(op_a_q) + SUM_W'(b_eff_c) + SUM_W'(op_mode_q);
  end

  // Operand capture, result registers, status flags and priority
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q        <= 1'b0;
      op_mode_q     <= 1'b0;
      op_id_q       <= 1'b0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_sum   <= '0;
      bus.rsp_carry <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      bus.rsp_ovf   <= 1'b0;
`endif
      busy          <= 1'b0;
    end else begin
      busy          <= (state_d != IDLE);
      bus.rsp_valid <= (state_d == RESP);
      if (accept_c) begin
        op_mode_q <= bus.req_mode[grant_id_c];
        op_id_q   <= grant_id_c;
        op_a_q    <= grant_id_c ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
        op_b_q    <= grant_id_c ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
      end
      if (state_q == EXEC) begin
        bus.rsp_sum   <= sum_c[WIDTH-1:0];
        bus.rsp_carry <= sum_c[WIDTH];
        bus.rsp_id    <= op_id_q;
`ifdef OVERFLOW_FLAG_EN
        // Effective operands share a sign but the result sign differs
        bus.rsp_ovf   <= (op_a_q[WIDTH-1] == b_eff_c[WIDTH-1]) &&
                         (sum_c[WIDTH-1] != op_a_q[WIDTH-1]);
`endif
      end
      // Priority passes to the other requester only when a response completes
      if ((state_q == RESP) && bus.rsp_ready) prio_q <= ~bus.rsp_id;
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed testbench for addsub_arbiter: reset, add/subtract results,
// round-robin alternation, response backpressure, reset mid-operation and
// (with OVERFLOW_FLAG_EN) the overflow flag.
module tb_addsub_arbiter;

  localparam int unsigned WIDTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   checks = 0;
  int   errors = 0;
`ifdef OVERFLOW_FLAG_EN
  logic exp_ovf = 1'bx;
`endif

  addsub_arbiter_if #(.WIDTH(WIDTH)) bus ();

  addsub_arbiter #(.WIDTH(WIDTH)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int id, input logic v, input logic m,
                         input logic [3:0] a, input logic [3:0] b);
    if (id == 0) begin
      bus.req_valid[0] = v;
      bus.req_mode[0]  = m;
      bus.req_a[3:0]   = a;
      bus.req_b[3:0]   = b;
    end else begin
      bus.req_valid[1] = v;
      bus.req_mode[1]  = m;
      bus.req_a[7:4]   = a;
      bus.req_b[7:4]   = b;
    end
  endtask

  // Called at a negedge in IDLE with rsp_ready=1; returns at a negedge in IDLE
  task automatic run_op(input string tag, input int id, input logic m,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] s, input logic c);
    set_req(id, 1'b1, m, a, b);
    #1;
    chk({tag, ".ready"}, 32'(bus.req_ready), (id == 0) ? 32'd1 : 32'd2);
    @(negedge clk);
    set_req(id, 1'b0, m, a, b);
    chk({tag, ".exec_busy"}, 32'(busy), 32'd1);
    chk({tag, ".exec_valid"}, 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk({tag, ".valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, ".id"}, 32'(bus.rsp_id), 32'(id));
    chk({tag, ".sum"}, 32'(bus.rsp_sum), 32'(s));
    chk({tag, ".carry"}, 32'(bus.rsp_carry), 32'(c));
`ifdef OVERFLOW_FLAG_EN
    if (exp_ovf !== 1'bx) chk({tag, ".ovf"}, 32'(bus.rsp_ovf), 32'(exp_ovf));
`endif
    @(negedge clk);
    chk({tag, ".done_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, ".done_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_mode  = 2'b00;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;

    // Reset held two edges with both requesters valid
    @(negedge clk);
    @(negedge clk);
    chk("rst.ready", 32'(bus.req_ready), 32'd0);
    chk("rst.valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.id", 32'(bus.rsp_id), 32'd0);
    chk("rst.sum", 32'(bus.rsp_sum), 32'd0);
    chk("rst.carry", 32'(bus.rsp_carry), 32'd0);
    bus.req_valid = 2'b00;
    rst_n         = 1'b1;
    @(negedge clk);

    // Single add, then subtracts from requester 1
    run_op("add0", 0, 1'b0, 4'b0101, 4'b1001, 4'b1110, 1'b0);
`ifdef OVERFLOW_FLAG_EN
    exp_ovf = 1'b1;
`endif
    run_op("sub_borrow", 1, 1'b1, 4'b0100, 4'b1011, 4'b1001, 1'b0);
`ifdef OVERFLOW_FLAG_EN
    exp_ovf = 1'b0;
`endif
    run_op("sub_equal", 1, 1'b1, 4'b1000, 4'b1000, 4'b0000, 1'b1);
`ifdef OVERFLOW_FLAG_EN
    exp_ovf = 1'bx;
`endif

    // Contention from reset: strict alternation starting with requester 0
    rst_n = 1'b0;
    set_req(0, 1'b1, 1'b0, 4'b0110, 4'b1101);
    set_req(1, 1'b1, 1'b0, 4'b0110, 4'b1101);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("rr%0d.ready", k), 32'(bus.req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      @(negedge clk);
      @(negedge clk);
      chk($sformatf("rr%0d.valid", k), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("rr%0d.id", k), 32'(bus.rsp_id), 32'(k % 2));
      chk($sformatf("rr%0d.sum", k), 32'(bus.rsp_sum), 32'h3);
      chk($sformatf("rr%0d.carry", k), 32'(bus.rsp_carry), 32'd1);
      @(negedge clk);
      #1;
    end
    bus.req_valid = 2'b00;

    // Backpressure: result held 5 cycles while requester 1 waits and changes A
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b1, 1'b0, 4'b0001, 4'b0001);
    set_req(1, 1'b1, 1'b1, 4'b0011, 4'b0001);
    #1;
    chk("bp.ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d.valid", i), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("bp%0d.sum", i), 32'(bus.rsp_sum), 32'h2);
      chk($sformatf("bp%0d.id", i), 32'(bus.rsp_id), 32'd0);
      chk($sformatf("bp%0d.ready", i), 32'(bus.req_ready), 32'd0);
      if (i == 2) set_req(1, 1'b1, 1'b1, 4'b0111, 4'b0001);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp.next_ready", 32'(bus.req_ready), 32'd2);
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    chk("bp.next_id", 32'(bus.rsp_id), 32'd1);
    chk("bp.next_sum", 32'(bus.rsp_sum), 32'h6);
    chk("bp.next_carry", 32'(bus.rsp_carry), 32'd1);
    @(negedge clk);

    // Overflow-relevant operand sets (sum/carry checked in every build)
`ifdef OVERFLOW_FLAG_EN
    exp_ovf = 1'b1;
`endif
    run_op("ovf_add", 0, 1'b0, 4'b0111, 4'b0001, 4'b1000, 1'b0);
    run_op("ovf_sub", 1, 1'b1, 4'b1000, 4'b0001, 4'b0111, 1'b1);
`ifdef OVERFLOW_FLAG_EN
    exp_ovf = 1'b0;
`endif
    run_op("no_ovf", 0, 1'b0, 4'b0011, 4'b1100, 4'b1111, 1'b0);
`ifdef OVERFLOW_FLAG_EN
    exp_ovf = 1'bx;
`endif

    // Reset during EXEC: operation abandoned, priority back to requester 0
    set_req(0, 1'b1, 1'b0, 4'b0001, 4'b0010);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid.busy", 32'(busy), 32'd0);
    chk("mid.valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid.ready", 32'(bus.req_ready), 32'd0);
    rst_n         = 1'b1;
    bus.req_valid = 2'b11;
    #1;
    chk("mid.prio", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("mid%0d.valid", i), 32'(bus.rsp_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
